md_array_frame_fifo: RTL and testbench

Parametrised FIFO whose entries are 2-D packed frames of ROWS x COLS elements, each ELEM_W bits wide. It is the sequential successor to the fixed 3x3x3 array typedefs used by the multi-dimension-array test design, and lets cocotb benches exercise handle access to packed multi-dimensional ports that change every cycle. It adds valid/ready handshakes, an optional transposed read view and a registered random-access peek port into any stored frame.

---
 rtl/md_array_frame_fifo.sv | 146 ++++++++++++++
 tb/tb_md_array_frame_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_array_frame_fifo.sv
// md_array_frame_fifo: FIFO of packed ROWS x COLS frames with a first-word-fall-through
// head, an optional transposed read view and a registered random-access peek port.
//
// Handshake: a frame moves on a rising edge only when valid and ready are both high
// on that side. wr_ready and rd_valid depend on count alone. They never look at
// wr_valid or rd_ready, so the producer and consumer may hold valid or ready
// combinationally without forming a loop.
module md_array_frame_fifo #(
    parameter int ELEM_W       = 3,
    parameter int ROWS         = 3,
    parameter int COLS         = 3,
    parameter int DEPTH        = 4,
    parameter int TRANSPOSE_EN = 1,
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int PW          = $clog2(DEPTH),
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int KW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0]  wr_frame,
    output logic                                   rd_valid,
    input  logic                                   rd_ready,
    input  logic                                   rd_transpose,
    output logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0]  rd_frame,
    output logic [CW-1:0]                          count,
    input  logic                                   peek_en,
    input  logic [PW-1:0]                          peek_idx,
    input  logic [RW-1:0]                          peek_row,
    input  logic [KW-1:0]                          peek_col,
    output logic [ELEM_W-1:0]                      peek_elem,
    output logic                                   peek_hit
);

    typedef logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] frame_t;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [PW:0]   DEPTH_X   = (PW + 1)'(DEPTH);
    localparam logic [RW:0]   ROWS_X    = (RW + 1)'(ROWS);
    localparam logic [KW:0]   COLS_X    = (KW + 1)'(COLS);

    // A transposed view only makes sense for square frames.
    if (TRANSPOSE_EN != 0 && ROWS != COLS) begin : g_bad_transpose
        $error("md_array_frame_fifo: TRANSPOSE_EN=1 requires ROWS == COLS");
    end

    frame_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    frame_t          head;
    frame_t          view;
    logic [PW:0]     peek_sum;
    logic [PW-1:0]   peek_addr;
    logic            peek_hit_c;
    logic [ELEM_W-1:0] peek_elem_c;

    assign wr_ready = (count != DEPTH_C);
    assign rd_valid = (count != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign head     = mem[rd_ptr];

    // Frame storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_frame;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    if (TRANSPOSE_EN != 0) begin : g_view
        // Output view of the head frame, optionally transposed; storage is untouched.
        always_comb begin
            view = head;
            if (rd_transpose) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        view[r][c] = head[c][r];
                    end
                end
            end
        end
    end else begin : g_view
        assign view = head;
    end

    // Empty FIFO drives zeros instead of whatever stale storage holds.
    always_comb begin
        rd_frame = '0;
        if (rd_valid) begin
            rd_frame = view;
        end
    end

    // Peek address is head-relative; the sum is below 2*DEPTH so one subtract wraps it.
    always_comb begin
        peek_sum  = {1'b0, rd_ptr} + {1'b0, peek_idx};
        peek_addr = (peek_sum >= DEPTH_X) ? PW'(peek_sum - DEPTH_X) : PW'(peek_sum);
        peek_hit_c = (CW'(peek_idx) < count) &&
                     ({1'b0, peek_row} < ROWS_X) &&
                     ({1'b0, peek_col} < COLS_X);
        peek_elem_c = '0;
        if (peek_hit_c) begin
            peek_elem_c = mem[peek_addr][peek_row][peek_col];
        end
    end

    // Registered peek result; the element holds when no request is made.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peek_elem <= '0;
            peek_hit  <= 1'b0;
        end else if (peek_en) begin
            peek_hit  <= peek_hit_c;
            peek_elem <= peek_elem_c;
        end else begin
            peek_hit  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_md_array_frame_fifo.sv
// Directed testbench for md_array_frame_fifo with default parameters (3x3x3 bits, depth 4).
module tb_md_array_frame_fifo;

    localparam int ELEM_W = 3;
    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int DEPTH  = 4;

    typedef logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] frame_t;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    frame_t      wr_frame;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_transpose;
    frame_t      rd_frame;
    logic [2:0]  count;
    logic        peek_en;
    logic [1:0]  peek_idx;
    logic [1:0]  peek_row;
    logic [1:0]  peek_col;
    logic [2:0]  peek_elem;
    logic        peek_hit;

    int n_total;
    int n_pass;
    logic [ROWS*COLS*ELEM_W-1:0] exp_q[$];
    frame_t f;

    md_array_frame_fifo #(
        .ELEM_W(ELEM_W), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .TRANSPOSE_EN(1)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_frame(wr_frame),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_transpose(rd_transpose),
        .rd_frame(rd_frame), .count(count),
        .peek_en(peek_en), .peek_idx(peek_idx), .peek_row(peek_row), .peek_col(peek_col),
        .peek_elem(peek_elem), .peek_hit(peek_hit)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // frame k: element (r,c) = (k+r+c)&7
    function automatic frame_t mk(input int k);
        frame_t x;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                x[r][c] = 3'((k + r + c) & 7);
        return x;
    endfunction

    // frame with element (r,c) = (r*3+c)&7
    function automatic frame_t mk_rc();
        frame_t x;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                x[r][c] = 3'((r * 3 + c) & 7);
        return x;
    endfunction

    function automatic frame_t tr(input frame_t x);
        frame_t y;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                y[r][c] = x[c][r];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // one rising edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [ROWS*COLS*ELEM_W-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(rd_frame), 64'(e));
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset = 1'b1;
        wr_valid = 1'b0; wr_frame = '0; rd_ready = 1'b0; rd_transpose = 1'b0;
        peek_en = 1'b0; peek_idx = '0; peek_row = '0; peek_col = '0;
        step(); step();
        reset = 1'b0;
        step();

        // reset / idle
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_rd_valid",  64'(rd_valid),  64'd0);
        chk("rst_wr_ready",  64'(wr_ready),  64'd1);
        chk("rst_rd_frame",  64'(rd_frame),  64'd0);
        chk("rst_peek_hit",  64'(peek_hit),  64'd0);
        chk("rst_peek_elem", 64'(peek_elem), 64'd0);

        // fill to full
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_frame = mk(k);
            chk("fill_wr_ready", 64'(wr_ready), 64'd1);
            exp_q.push_back(mk(k));
            step();
        end
        chk("full_count",    64'(count),    64'd4);
        chk("full_wr_ready", 64'(wr_ready), 64'd0);
        chk("full_rd_valid", 64'(rd_valid), 64'd1);

        // fifth push held while full
        wr_frame = mk(4);
        step();
        chk("held_count", 64'(count), 64'd4);
        rd_ready = 1'b1;
        pop_check("pop_f0");
        step();
        chk("after_pop_count", 64'(count), 64'd3);
        rd_ready = 1'b0;
        chk("after_pop_wr_ready", 64'(wr_ready), 64'd1);
        exp_q.push_back(mk(4));
        step();
        wr_valid = 1'b0;
        chk("refill_count", 64'(count), 64'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pop_check("drain");
            step();
        end
        rd_ready = 1'b0;
        chk("drained_count",    64'(count),    64'd0);
        chk("drained_rd_valid", 64'(rd_valid), 64'd0);
        chk("drained_rd_frame", 64'(rd_frame), 64'd0);

        // steady-state streaming with two frames stored
        wr_valid = 1'b1;
        for (int k = 10; k < 12; k++) begin
            wr_frame = mk(k); exp_q.push_back(mk(k));
            step();
        end
        rd_ready = 1'b1;
        for (int k = 12; k < 22; k++) begin
            chk("stream_count", 64'(count), 64'd2);
            pop_check("stream_order");
            wr_frame = mk(k); exp_q.push_back(mk(k));
            step();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pop_check("stream_drain");
            step();
        end
        rd_ready = 1'b0;
        chk("stream_end_count", 64'(count), 64'd0);

        // transposed view toggling every cycle
        wr_valid = 1'b1; wr_frame = mk_rc();
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_transpose = i[0];
            #1;
            f = rd_frame;
            if (i[0]) begin
                chk("tr_elem02_t", 64'(f[0][2]), 64'd6);
                chk("tr_frame_t",  64'(rd_frame), 64'(tr(mk_rc())));
            end else begin
                chk("tr_elem02_n", 64'(f[0][2]), 64'd2);
            end
            step();
        end
        rd_transpose = 1'b0;
        rd_ready = 1'b1;
        #1;
        chk("tr_stored", 64'(rd_frame), 64'(mk_rc()));
        step();
        rd_ready = 1'b0;

        // peek port
        wr_valid = 1'b1;
        for (int k = 20; k < 23; k++) begin
            wr_frame = mk(k); exp_q.push_back(mk(k));
            step();
        end
        wr_valid = 1'b0;
        peek_en = 1'b1; peek_idx = 2'd1; peek_row = 2'd2; peek_col = 2'd0;
        step();
        chk("peek1_hit",  64'(peek_hit),  64'd1);
        chk("peek1_elem", 64'(peek_elem), 64'd7);
        peek_en = 1'b0;
        step();
        chk("peek_idle_hit",  64'(peek_hit),  64'd0);
        chk("peek_idle_hold", 64'(peek_elem), 64'd7);
        peek_en = 1'b1; peek_idx = 2'd3;
        step();
        chk("peek3_hit",  64'(peek_hit),  64'd0);
        chk("peek3_elem", 64'(peek_elem), 64'd0);
        peek_idx = 2'd0; peek_row = 2'd3; peek_col = 2'd0;
        step();
        chk("peek_row3_hit", 64'(peek_hit), 64'd0);
        // peek alongside a pop sees the pre-edge head (frame 20, elem (0,1) = 5)
        peek_idx = 2'd0; peek_row = 2'd0; peek_col = 2'd1;
        rd_ready = 1'b1;
        pop_check("peek_pop_head");
        step();
        rd_ready = 1'b0;
        chk("peek_pop_hit",  64'(peek_hit),  64'd1);
        chk("peek_pop_elem", 64'(peek_elem), 64'd5);
        // head is now frame 21: (2,2) = 25&7 = 1
        peek_idx = 2'd0; peek_row = 2'd2; peek_col = 2'd2;
        step();
        chk("peek_new_head", 64'(peek_elem), 64'd1);

        // asynchronous reset with three frames stored and a peek result in flight
        wr_valid = 1'b1; wr_frame = mk(23);
        step();
        wr_valid = 1'b0;
        chk("pre_reset_count", 64'(count),    64'd3);
        chk("pre_reset_hit",   64'(peek_hit), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_count",    64'(count),    64'd0);
        chk("async_rd_valid", 64'(rd_valid), 64'd0);
        chk("async_rd_frame", 64'(rd_frame), 64'd0);
        chk("async_wr_ready", 64'(wr_ready), 64'd1);
        chk("async_peek_hit", 64'(peek_hit), 64'd0);
        chk("async_peek_elem", 64'(peek_elem), 64'd0);
        peek_en = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        step();

        // round trip after reset
        wr_valid = 1'b1; wr_frame = mk(30); exp_q.push_back(mk(30));
        step();
        wr_valid = 1'b0;
        chk("rt_count", 64'(count), 64'd1);
        rd_ready = 1'b1;
        pop_check("rt_frame");
        step();
        rd_ready = 1'b0;
        chk("rt_empty", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
